// File: rtl/myo_logger_pkg.sv
// Shared constants and record helpers for the myo status logger.
// A record is four 32-bit words; W0 sits in the top bits so it reads first.
package myo_logger_pkg;

    localparam int RECORD_W = 128;

    localparam logic [7:0] ADDR_W0       = 8'h00;
    localparam logic [7:0] ADDR_W1       = 8'h01;
    localparam logic [7:0] ADDR_W2       = 8'h02;
    localparam logic [7:0] ADDR_W3       = 8'h03;
    localparam logic [7:0] ADDR_LEVEL    = 8'h04;
    localparam logic [7:0] ADDR_OVERFLOW = 8'h05;
    localparam logic [7:0] ADDR_STATUS   = 8'h06;
    localparam logic [7:0] ADDR_MASK     = 8'h07;

    localparam logic [7:0] ADDR_WR_ENABLE = 8'h00;
    localparam logic [7:0] ADDR_WR_FLUSH  = 8'h01;
    localparam logic [7:0] ADDR_WR_MASK   = 8'h02;

    localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        REC_W0 = 2'd0,
        REC_W1 = 2'd1,
        REC_W2 = 2'd2,
        REC_W3 = 2'd3
    } rec_word_e;

    function automatic logic [RECORD_W-1:0] pack_record(
        input logic [7:0]  motor,
        input logic [23:0] ts,
        input logic [31:0] position,
        input logic [15:0] velocity,
        input logic [15:0] current,
        input logic [15:0] displacement,
        input logic [15:0] pwm
    );
        return {motor, ts, position, velocity, current, displacement, pwm};
    endfunction

    function automatic logic [31:0] rec_word(
        input logic [RECORD_W-1:0] rec,
        input rec_word_e           idx
    );
        logic [31:0] w;
        case (idx)
            REC_W0:  w = rec[127:96];
            REC_W1:  w = rec[95:64];
            REC_W2:  w = rec[63:32];
            default: w = rec[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/myo_record_fifo.sv
// Single-clock record FIFO with extra-MSB pointers and a registered head word.
// A push into the slot that becomes head is bypassed straight into the head register.
module myo_record_fifo
    import myo_logger_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push_i,
    input  logic [RECORD_W-1:0] push_data_i,
    input  logic                pop_i,
    input  logic                flush_i,
    output logic [RECORD_W-1:0] head_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [AW:0]         level_o
);

    logic [RECORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [RECORD_W-1:0] head_q;
    logic                do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = head_q;

    // Flush overrides everything; a full FIFO still takes a push when a pop frees a slot.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]))
                head_q <= push_data_i;
            else
                head_q <= mem[rd_ptr_d[AW-1:0]];
        end
    end

endmodule

// File: rtl/myo_status_logger.sv
// Timestamped, loss-counted capture of per-motor status samples, drained over Avalon-MM.
// Holds the microsecond timestamp, accept/overflow logic, config registers and read FSM.
//
//  state   | meaning
//  IDLE    | no read in progress
//  RD_WAIT | read presented this cycle (IDLE + read): waitrequest high, readdata registered
//  RD_DONE | waitrequest low, readdata valid; a 0x03 read pops the head here
module myo_status_logger
    import myo_logger_pkg::*;
#(
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int FIFO_DEPTH       = 64,
    parameter int CLOCK_SPEED_HZ   = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [7:0]  sample_motor,
    input  logic [31:0] sample_position,
    input  logic [15:0] sample_velocity,
    input  logic [15:0] sample_current,
    input  logic [15:0] sample_displacement,
    input  logic [15:0] sample_pwm,
    input  logic [15:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        fifo_nonempty
);

    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int TICK_CYCLES = (CLOCK_SPEED_HZ / 1_000_000 < 1) ? 1 : CLOCK_SPEED_HZ / 1_000_000;
    localparam logic [31:0] TICK_RELOAD = 32'(TICK_CYCLES - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RD_DONE = 2'd2;

    logic [1:0]                  state_q, state_d, state_cur;
    logic [31:0]                 readdata_q, readdata_d;
    logic                        rd_pop_q, rd_pop_d;
    logic                        enable_q, enable_d;
    logic [NUMBER_OF_MOTORS-1:0] motor_mask_q, motor_mask_d;
    logic [31:0]                 overflow_q, overflow_d;
    logic [31:0]                 prescaler_q, prescaler_d;
    logic [23:0]                 ts_q, ts_d;
    logic                        fifo_nonempty_q;

    logic [7:0]          addr8;
    logic                unused_addr;
    logic                tick, mask_hit, accept, flush, pop_req;
    logic [31:0]         rd_word;
    logic [RECORD_W-1:0] fifo_head;
    logic                fifo_full, fifo_empty;
    logic [AW:0]         fifo_level;

    assign addr8       = address[7:0];
    assign unused_addr = ^address[15:8];

    // Prescaler counts down; terminal count advances the timestamp and reloads.
    assign tick        = (prescaler_q == '0);
    assign prescaler_d = tick ? TICK_RELOAD : prescaler_q - 32'd1;
    assign ts_d        = tick ? ts_q + 24'd1 : ts_q;

    always_comb begin
        mask_hit = 1'b0;
        for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
            if (sample_motor == 8'(i)) mask_hit = motor_mask_q[i];
        end
    end

    assign accept = sample_valid && enable_q && mask_hit;
    assign flush  = write && (addr8 == ADDR_WR_FLUSH);

    always_comb begin
        enable_d     = enable_q;
        motor_mask_d = motor_mask_q;
        if (write && addr8 == ADDR_WR_ENABLE) enable_d = (writedata != 32'd0);
        if (write && addr8 == ADDR_WR_MASK)   motor_mask_d = writedata[NUMBER_OF_MOTORS-1:0];
    end

    always_comb begin
        overflow_d = overflow_q;
        if (flush)
            overflow_d = '0;
        else if (accept && fifo_full && !pop_req && overflow_q != 32'hFFFF_FFFF)
            overflow_d = overflow_q + 32'd1;
    end

    myo_record_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (accept),
        .push_data_i (pack_record(sample_motor, ts_q, sample_position, sample_velocity,
                                  sample_current, sample_displacement, sample_pwm)),
        .pop_i       (pop_req),
        .flush_i     (flush),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    always_comb begin
        rd_word = DEADBEEF;
        case (addr8)
            ADDR_W0, ADDR_W1, ADDR_W2, ADDR_W3:
                rd_word = fifo_empty ? 32'd0 : rec_word(fifo_head, rec_word_e'(addr8[1:0]));
            ADDR_LEVEL:    rd_word = 32'(fifo_level);
            ADDR_OVERFLOW: rd_word = overflow_q;
            ADDR_STATUS:   rd_word = {29'd0, fifo_full, fifo_empty, enable_q};
            ADDR_MASK:     rd_word = 32'(motor_mask_q);
            default:       rd_word = DEADBEEF;
        endcase
    end

    // RD_WAIT is never registered: it is the IDLE cycle in which read is already high.
    assign state_cur = (state_q == IDLE && read) ? RD_WAIT : state_q;

    always_comb begin
        state_d    = IDLE;
        readdata_d = readdata_q;
        rd_pop_d   = 1'b0;
        pop_req    = 1'b0;
        case (state_cur)
            RD_WAIT: begin
                state_d    = RD_DONE;
                readdata_d = rd_word;
                rd_pop_d   = (addr8 == ADDR_W3) && !fifo_empty;
            end
            RD_DONE: begin
                state_d = IDLE;
                pop_req = rd_pop_q;
            end
            default: state_d = IDLE;
        endcase
    end

    assign waitrequest   = (state_cur == RD_WAIT) && !reset;
    assign readdata      = readdata_q;
    assign fifo_nonempty = fifo_nonempty_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            readdata_q      <= '0;
            rd_pop_q        <= 1'b0;
            enable_q        <= 1'b0;
            motor_mask_q    <= '1;
            overflow_q      <= '0;
            prescaler_q     <= '0;
            ts_q            <= '0;
            fifo_nonempty_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            readdata_q      <= readdata_d;
            rd_pop_q        <= rd_pop_d;
            enable_q        <= enable_d;
            motor_mask_q    <= motor_mask_d;
            overflow_q      <= overflow_d;
            prescaler_q     <= prescaler_d;
            ts_q            <= ts_d;
            fifo_nonempty_q <= !fifo_empty;
        end
    end

endmodule

// File: tb/tb_myo_status_logger.sv
// Directed bench for myo_status_logger: register-read vector tables plus
// hand-written sequences for pop/push collisions, flush races, timestamp wrap and reset mid-read.
module tb_myo_status_logger;

    localparam int NM     = 6;
    localparam int DEPTH  = 4;
    localparam int CLK_HZ = 2_000_000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [7:0]  sample_motor = '0;
    logic [31:0] sample_position = '0;
    logic [15:0] sample_velocity = '0;
    logic [15:0] sample_current = '0;
    logic [15:0] sample_displacement = '0;
    logic [15:0] sample_pwm = '0;
    logic [15:0] address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        fifo_nonempty;

    myo_status_logger #(
        .NUMBER_OF_MOTORS (NM),
        .FIFO_DEPTH       (DEPTH),
        .CLOCK_SPEED_HZ   (CLK_HZ)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .sample_valid        (sample_valid),
        .sample_motor        (sample_motor),
        .sample_position     (sample_position),
        .sample_velocity     (sample_velocity),
        .sample_current      (sample_current),
        .sample_displacement (sample_displacement),
        .sample_pwm          (sample_pwm),
        .address             (address),
        .read                (read),
        .write               (write),
        .writedata           (writedata),
        .readdata            (readdata),
        .waitrequest         (waitrequest),
        .fifo_nonempty       (fifo_nonempty)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] mask;
        logic [31:0] exp;
        string       name;
    } rd_vec_t;

    rd_vec_t vecs[$];

    // Sample injected during the RD_DONE cycle of the next read when inject=1.
    logic        inject = 1'b0;
    logic [7:0]  inj_motor = '0;
    logic [31:0] inj_pos = '0;
    logic [15:0] inj_pwm = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic avm_read(input logic [7:0] a, output logic [31:0] data);
        int n;
        @(negedge clock);
        address = {8'h00, a};
        read    = 1'b1;
        #1;
        n = 0;
        while (waitrequest && n < 8) begin
            @(negedge clock);
            #1;
            n++;
        end
        data = readdata;
        if (inject) begin
            sample_motor        = inj_motor;
            sample_position     = inj_pos;
            sample_velocity     = '0;
            sample_current      = '0;
            sample_displacement = '0;
            sample_pwm          = inj_pwm;
            sample_valid        = 1'b1;
        end
        check($sformatf("rd_wait_cycles_%02h", a), n, 32'd1);
        @(posedge clock);
        #1;
        read         = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic avm_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clock);
        address   = {8'h00, a};
        writedata = d;
        write     = 1'b1;
        #1;
        check("wr_no_stall", {31'd0, waitrequest}, 32'd0);
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic push(input logic [7:0] m, input logic [31:0] p, input logic [15:0] v,
                        input logic [15:0] c, input logic [15:0] d, input logic [15:0] w);
        @(negedge clock);
        sample_motor        = m;
        sample_position     = p;
        sample_velocity     = v;
        sample_current      = c;
        sample_displacement = d;
        sample_pwm          = w;
        sample_valid        = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
    endtask

    task automatic add(input logic [7:0] a, input logic [31:0] m, input logic [31:0] e, input string n);
        vecs.push_back('{addr: a, mask: m, exp: e, name: n});
    endtask

    task automatic apply_vecs();
        logic [31:0] d;
        for (int i = 0; i < vecs.size(); i++) begin
            avm_read(vecs[i].addr, d);
            check(vecs[i].name, d & vecs[i].mask, vecs[i].exp);
        end
        vecs.delete();
    endtask

    initial begin
        logic [31:0] d;

        repeat (3) @(negedge clock);
        check("rst_readdata", readdata, 32'd0);
        check("rst_waitrequest", {31'd0, waitrequest}, 32'd0);
        check("rst_nonempty", {31'd0, fifo_nonempty}, 32'd0);
        reset = 1'b0;

        add(8'h04, 32'hFFFFFFFF, 32'd0,          "rst_level");
        add(8'h05, 32'hFFFFFFFF, 32'd0,          "rst_overflow");
        add(8'h06, 32'hFFFFFFFF, 32'h2,          "rst_status");
        add(8'h07, 32'hFFFFFFFF, 32'h3F,         "rst_mask");
        add(8'h20, 32'hFFFFFFFF, 32'hDEADBEEF,   "unmapped_20");
        add(8'h08, 32'hFFFFFFFF, 32'hDEADBEEF,   "unmapped_08");
        add(8'h00, 32'hFFFFFFFF, 32'd0,          "empty_w0");
        apply_vecs();

        // Single record round trip
        avm_write(8'h00, 32'd1);
        push(8'd2, 32'h12345678, 16'hFFFB, 16'h0064, 16'h0007, 16'hFED4);
        @(negedge clock);
        check("nonempty_after_push", {31'd0, fifo_nonempty}, 32'd1);
        add(8'h04, 32'hFFFFFFFF, 32'd1,          "t1_level");
        add(8'h06, 32'hFFFFFFFF, 32'h1,          "t1_status");
        add(8'h00, 32'hFF000000, 32'h02000000,   "t1_w0_motor");
        add(8'h01, 32'hFFFFFFFF, 32'h12345678,   "t1_w1");
        add(8'h02, 32'hFFFFFFFF, 32'hFFFB0064,   "t1_w2");
        add(8'h03, 32'hFFFFFFFF, 32'h0007FED4,   "t1_w3");
        add(8'h04, 32'hFFFFFFFF, 32'd0,          "t1_level_after_pop");
        add(8'h06, 32'hFFFFFFFF, 32'h3,          "t1_status_after_pop");
        apply_vecs();

        // Overfill: 6 samples into a 4-deep FIFO
        for (int i = 1; i <= 6; i++)
            push(8'(i - 1), 32'(i), 16'h0, 16'h0, 16'(i), 16'(16'h100 + i));
        add(8'h04, 32'hFFFFFFFF, 32'd4, "t2_level");
        add(8'h05, 32'hFFFFFFFF, 32'd2, "t2_overflow");
        add(8'h06, 32'hFFFFFFFF, 32'h5, "t2_status_full");
        apply_vecs();
        for (int i = 1; i <= 4; i++) begin
            avm_read(8'h01, d);
            check($sformatf("t2_rec%0d_w1", i), d, 32'(i));
            avm_read(8'h03, d);
            check($sformatf("t2_rec%0d_w3", i), d, {16'(i), 16'(16'h100 + i)});
        end
        add(8'h04, 32'hFFFFFFFF, 32'd0, "t2_drained");
        apply_vecs();

        // Push collides with the pop of a full FIFO
        for (int i = 0; i < 4; i++)
            push(8'd1, 32'(32'hA0 + i), 16'h0, 16'h0, 16'h0, 16'(16'hA0 + i));
        add(8'h04, 32'hFFFFFFFF, 32'd4, "t4_level_full");
        apply_vecs();
        inj_motor = 8'd1;
        inj_pos   = 32'hA4;
        inj_pwm   = 16'hA4;
        inject    = 1'b1;
        avm_read(8'h03, d);
        inject    = 1'b0;
        check("t4_popped_w3", d, 32'h000000A0);
        add(8'h04, 32'hFFFFFFFF, 32'd4, "t4_level_kept");
        add(8'h05, 32'hFFFFFFFF, 32'd2, "t4_overflow_kept");
        apply_vecs();
        for (int i = 1; i <= 4; i++) begin
            avm_read(8'h01, d);
            check($sformatf("t4_order%0d", i), d, 32'(32'hA0 + i));
            avm_read(8'h03, d);
        end

        // Flush clears overflow; mask filters motors
        avm_write(8'h01, 32'd0);
        add(8'h05, 32'hFFFFFFFF, 32'd0, "t3_flush_overflow");
        apply_vecs();
        avm_write(8'h02, 32'h1);
        push(8'd0, 32'h55, 16'h0, 16'h0, 16'h0, 16'h0);
        push(8'd1, 32'h56, 16'h0, 16'h0, 16'h0, 16'h0);
        push(8'd9, 32'h57, 16'h0, 16'h0, 16'h0, 16'h0);
        add(8'h04, 32'hFFFFFFFF, 32'd1,        "t3_level");
        add(8'h05, 32'hFFFFFFFF, 32'd0,        "t3_overflow");
        add(8'h07, 32'hFFFFFFFF, 32'h1,        "t3_mask");
        add(8'h00, 32'hFF000000, 32'h00000000, "t3_motor");
        add(8'h01, 32'hFFFFFFFF, 32'h55,       "t3_pos");
        apply_vecs();

        // Flush on the same cycle as an accepted sample
        @(negedge clock);
        address             = 16'h0001;
        writedata           = 32'd0;
        write               = 1'b1;
        sample_motor        = 8'd0;
        sample_position     = 32'h66;
        sample_valid        = 1'b1;
        @(negedge clock);
        write        = 1'b0;
        sample_valid = 1'b0;
        @(negedge clock);
        check("t5_nonempty", {31'd0, fifo_nonempty}, 32'd0);
        add(8'h04, 32'hFFFFFFFF, 32'd0, "t5_level");
        add(8'h05, 32'hFFFFFFFF, 32'd0, "t5_overflow");
        add(8'h06, 32'hFFFFFFFF, 32'h3, "t5_status");
        add(8'h03, 32'hFFFFFFFF, 32'd0, "t5_empty_w3");
        add(8'h04, 32'hFFFFFFFF, 32'd0, "t5_level_after_w3");
        apply_vecs();

        // Enable gate and motor id range
        avm_write(8'h02, 32'h3F);
        avm_write(8'h00, 32'd0);
        push(8'd2, 32'h1, 16'h0, 16'h0, 16'h0, 16'h0);
        add(8'h04, 32'hFFFFFFFF, 32'd0, "dis_level");
        add(8'h06, 32'hFFFFFFFF, 32'h2, "dis_status");
        apply_vecs();
        avm_write(8'h00, 32'h80000000);
        push(8'd6, 32'h2, 16'h0, 16'h0, 16'h0, 16'h0);
        add(8'h04, 32'hFFFFFFFF, 32'd0, "motor6_ignored");
        apply_vecs();
        push(8'd5, 32'h3, 16'h0, 16'h0, 16'h0, 16'h0);
        add(8'h04, 32'hFFFFFFFF, 32'd1, "motor5_kept");
        apply_vecs();
        avm_write(8'h01, 32'd0);

        // Timestamp wrap: two ticks (4 cycles at 2 cycles/tick) after 0xFFFFFE
        @(negedge clock);
        force dut.ts_q = 24'hFFFFFE;
        #1;
        release dut.ts_q;
        repeat (4) @(posedge clock);
        push(8'd3, 32'h77, 16'h0, 16'h0, 16'h0, 16'h0);
        add(8'h00, 32'hFFFFFFFF, 32'h03000000, "t6_ts_wrap");
        apply_vecs();

        // Reset in the middle of a read
        @(negedge clock);
        address = 16'h0004;
        read    = 1'b1;
        #1;
        check("mid_wait_before", {31'd0, waitrequest}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_wait_reset", {31'd0, waitrequest}, 32'd0);
        check("mid_readdata", readdata, 32'd0);
        check("mid_nonempty", {31'd0, fifo_nonempty}, 32'd0);
        #1;
        read = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        add(8'h07, 32'hFFFFFFFF, 32'h3F, "post_rst_mask");
        add(8'h04, 32'hFFFFFFFF, 32'd0,  "post_rst_level");
        add(8'h06, 32'hFFFFFFFF, 32'h2,  "post_rst_status");
        apply_vecs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
